// File: rtl/md_pkg.sv
// Shared encodings and widths for the multiply/divide unit.
package md_pkg;

   localparam int unsigned MD_CNT_W = 4;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   typedef enum logic [0:0] {StIdle, StRun} md_state_e;

   // Multi-cycle ops are exactly the codes with the top bit clear.
   function automatic logic is_multdiv(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit.
interface md_unit_ctrl_if;

   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        id_multdiv;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, md_op, rs_data, rt_data, id_multdiv,
      input  busy, md_stall, hi, lo
   );

   modport slave (
      input  start, md_op, rs_data, rt_data, id_multdiv,
      output busy, md_stall, hi, lo
   );

endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit product and truncating quotient/remainder.
module md_arith (
   input  logic        i_signed,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_prod,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem,
   output logic        o_div_zero
);

   logic        w_a_neg;
   logic        w_b_neg;
   logic [63:0] w_a_ext;
   logic [63:0] w_b_ext;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_b_safe;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;

   assign w_a_neg = i_signed & i_a[31];
   assign w_b_neg = i_signed & i_b[31];

   assign w_a_ext = {{32{w_a_neg}}, i_a};
   assign w_b_ext = {{32{w_b_neg}}, i_b};
   assign o_prod  = w_a_ext * w_b_ext;

   // Magnitude division avoids the 0x80000000 / -1 corner; its magnitude fits unsigned.
   assign w_a_mag    = w_a_neg ? (32'd0 - i_a) : i_a;
   assign w_b_mag    = w_b_neg ? (32'd0 - i_b) : i_b;
   assign o_div_zero = (i_b == 32'd0);
   assign w_b_safe   = o_div_zero ? 32'd1 : w_b_mag;
   assign w_q_mag    = w_a_mag / w_b_safe;
   assign w_r_mag    = w_a_mag % w_b_safe;

   assign o_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign o_rem  = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

endmodule

// File: rtl/md_unit_ctrl.sv
// EX-stage multiply/divide scheduler: owns HI/LO, sequences fixed-latency ops, drives ID stall.
module md_unit_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   md_unit_ctrl_if.slave md_bus
);

   localparam logic [MD_CNT_W-1:0] MultCnt = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DivCnt  = MD_CNT_W'(DIV_CYCLES);

   md_state_e           r_state, w_state_nxt;
   logic [MD_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]         r_hi, w_hi_nxt;
   logic [31:0]         r_lo, w_lo_nxt;
   logic [31:0]         r_pend_hi, w_pend_hi_nxt;
   logic [31:0]         r_pend_lo, w_pend_lo_nxt;
   logic                r_pend_we, w_pend_we_nxt;

   logic [63:0] w_prod;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_div_zero;
   logic        w_busy;

   md_arith u_arith (
      .i_signed   (~md_bus.md_op[0]),
      .i_a        (md_bus.rs_data),
      .i_b        (md_bus.rt_data),
      .o_prod     (w_prod),
      .o_quot     (w_quot),
      .o_rem      (w_rem),
      .o_div_zero (w_div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_we <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
         r_pend_we <= w_pend_we_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_pend_hi_nxt = r_pend_hi;
      w_pend_lo_nxt = r_pend_lo;
      w_pend_we_nxt = r_pend_we;
      unique case (r_state)
         StIdle: begin
            if (md_bus.start) begin
               case (md_bus.md_op)
                  MD_MULT, MD_MULTU: begin
                     w_pend_hi_nxt = w_prod[63:32];
                     w_pend_lo_nxt = w_prod[31:0];
                     w_pend_we_nxt = 1'b1;
                     w_cnt_nxt     = MultCnt;
                     w_state_nxt   = StRun;
                  end
                  MD_DIV, MD_DIVU: begin
                     w_pend_hi_nxt = w_rem;
                     w_pend_lo_nxt = w_quot;
                     w_pend_we_nxt = ~w_div_zero;
                     w_cnt_nxt     = DivCnt;
                     w_state_nxt   = StRun;
                  end
                  MD_MTHI: w_hi_nxt = md_bus.rs_data;
                  MD_MTLO: w_lo_nxt = md_bus.rs_data;
                  default: ;
               endcase
            end
         end
         StRun: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == MD_CNT_W'(1)) begin
               w_state_nxt = StIdle;
               if (r_pend_we) begin
                  w_hi_nxt = r_pend_hi;
                  w_lo_nxt = r_pend_lo;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign w_busy          = (r_state == StRun);
   assign md_bus.busy     = w_busy;
   assign md_bus.hi       = r_hi;
   assign md_bus.lo       = r_lo;
   // Combinational so an mfhi/mflo right behind a fresh mult stalls in the issue cycle.
   assign md_bus.md_stall = md_bus.id_multdiv &
                            (w_busy | (md_bus.start & is_multdiv(md_bus.md_op)));

   ap_no_start_when_busy : assert property (
      @(posedge clk) disable iff (!reset) !(md_bus.start && w_busy)
   ) else $error("md_unit_ctrl: start asserted while busy");

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multiply/divide scheduler for the EX stage of the pipelined CPU. Owns the HI/LO registers.
- Sequences mult/multu/div/divu over a fixed multi-cycle latency and applies mthi/mtlo writes.
- Drives the ID-stage stall for any HI/LO-class instruction while an operation is in flight.
- Sits beside the ALU. Takes operands forwarded into EX and a decoded md_op from the EX pipeline register.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction is a mult/div/mthi/mtlo; valid for one cycle.
- md_op  input  3  operation code (see package).
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- id_multdiv  input  1  ID stage holds a HI/LO-class instruction.
- busy  output  1  multi-cycle operation in flight.
- md_stall  output  1  stall request to the hazard unit.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts the operation with no HI/LO commit.
- States: IDLE (busy=0) and RUN (busy=1). busy is registered and equals (state==RUN).
- IDLE, start with mult/multu:
  - Latch the full 64-bit product of rs_data*rt_data (signed/unsigned per op) into pending_hi/pending_lo.
  - Load counter=MULT_CYCLES and go to RUN.
- IDLE, start with div/divu:
  - pending_lo = quotient, pending_hi = remainder.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Load counter=DIV_CYCLES and go to RUN.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Divide by zero (rt_data==0): the op still occupies DIV_CYCLES, but HI/LO stay unchanged at commit.
- IDLE, start with mthi: hi<=rs_data at the next edge; busy stays 0.
- IDLE, start with mtlo: lo<=rs_data at the next edge; busy stays 0.
- RUN: counter decrements each cycle. On the edge where counter==1: commit hi/lo from pending, go to IDLE, busy->0.
- Timing: start sampled at edge T gives busy=1 for cycles T+1..T+N. The new hi/lo are visible from cycle T+N+1, together with busy=0.
- md_stall = id_multdiv & (busy | (start & md_op is mult/multu/div/divu)). It is combinational, so mfhi/mflo behind a just-issued mult stalls immediately.
- start while busy: protocol violation, since the stall rule prevents it. The block ignores it, keeps the current operation, and flags a simulation assertion.
- md_op values 110/111 with start=1: no-op.
- hi/lo outputs are the architectural registers. mfhi/mflo read them directly; they are never pending values.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings: MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101.
  - Counter width constant MD_CNT_W=4.
- One natural sub-module, md_arith: combinational 64-bit product and signed/unsigned quotient/remainder with the zero-divisor flag. The controller instantiates it and registers its outputs into pending.

Test Plan:
- multu: rs=0xFFFFFFFF, rt=2, start at T. Expect busy high T+1..T+5; at T+6 hi=0x00000001, lo=0xFFFFFFFE, busy=0.
- div: rs=-7 (0xFFFFFFF9), rt=2. After 10 busy cycles: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with divu: lo=0x7FFFFFFC, hi=1.
- Divide by zero: mthi 0x1234 and mtlo 0x5678 first, then div rs=5, rt=0. Expect busy for 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
- Stall: mult issued at T with id_multdiv=1 in the same cycle. Expect md_stall=1 from cycle T through T+5 and 0 at T+6. Expect md_stall=0 throughout when id_multdiv=0.
- Async reset: assert reset=0 mid-div at counter=4, between edges. Expect busy, hi and lo to go to 0 immediately, with no commit after release.
- Signed overflow: div rs=0x80000000, rt=0xFFFFFFFF. Expect lo=0x80000000, hi=0 and no X values.
